cv32e40x_wb_stage: RTL and testbench

Write-back stage: the last pipeline stage, directly downstream of the execute stage, consuming the EX/WB pipeline register. It completes every valid instruction. For loads it waits for the LSU response, then extracts, sign/zero-extends, and merges misaligned two-part data. It drives the register-file write port and the CSR write port, and signals retirement and bus errors to the controller.

---
 rtl/cv32e40x_pkg.sv | 34 +++
 rtl/cv32e40x_wb_load_align.sv | 40 ++++
 rtl/cv32e40x_wb_stage.sv | 102 ++++++++++
 tb/tb_cv32e40x_wb_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x write-back slice: WB FSM states, LSU access
// size, the EX/WB pipeline register and the controller's WB controls.
package cv32e40x_pkg;

  typedef enum logic {S_IDLE, S_MISAL} wb_state_e;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic        instr_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lsu_en;
    lsu_size_e   lsu_size;
    logic        lsu_sext;
    logic [1:0]  lsu_addr_lsb;
    logic        lsu_misaligned_first;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        illegal_insn;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic kill_wb;
    logic halt_wb;
  } ctrl_fsm_t;

endpackage

// File: rtl/cv32e40x_wb_load_align.sv
// Combinational load data path: merges the two halves of a misaligned access,
// then extracts the addressed byte/half/word and sign- or zero-extends it.
module cv32e40x_wb_load_align
  import cv32e40x_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_rdata_q,
  input  logic [1:0]  i_off,
  input  lsu_size_e   i_size,
  input  logic        i_sext,
  input  logic        i_misal,
  output logic [31:0] o_data
);

  logic [31:0] w_word;
  logic [31:0] w_shift;
  logic [1:0]  w_off;

  always_comb begin
    w_word = i_rdata;
    w_off  = i_off;
    // A merged word is already aligned to bit 0, so extraction uses offset 0.
    if (i_misal) begin
      w_off = 2'd0;
      case (i_off)
        2'd1:    w_word = {i_rdata[7:0],  i_rdata_q[31:8]};
        2'd2:    w_word = {i_rdata[15:0], i_rdata_q[31:16]};
        2'd3:    w_word = {i_rdata[23:0], i_rdata_q[31:24]};
        default: w_word = i_rdata;
      endcase
    end
    w_shift = w_word >> {w_off, 3'b000};
    case (i_size)
      LSU_SIZE_B: o_data = {{24{i_sext & w_shift[7]}},  w_shift[7:0]};
      LSU_SIZE_H: o_data = {{16{i_sext & w_shift[15]}}, w_shift[15:0]};
      default:    o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Write-back stage: completes instructions, waits for LSU responses, merges
// misaligned two-part loads and drives the RF/CSR write ports and retirement.
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_wb_pipe_t ex_wb_pipe_i,
  input  ctrl_fsm_t   ctrl_fsm_i,
  input  logic        lsu_valid_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        lsu_err_i,
  output logic        lsu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        csr_we_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        wb_valid_o,
  output logic        wb_bus_err_o,
  output logic        wb_ready_o
);

  wb_state_e   r_state, w_state_nxt;
  logic [31:0] r_rdata_q;
  logic [1:0]  r_off_q;
  logic        r_err_q;

  logic        w_vld, w_done, w_resp, w_first, w_bus_err, w_suppress, w_misal;
  logic [31:0] w_load_data;

  assign w_vld      = ex_wb_pipe_i.instr_valid && !ctrl_fsm_i.kill_wb && !ctrl_fsm_i.halt_wb;
  assign w_done     = w_vld && (!ex_wb_pipe_i.lsu_en || lsu_valid_i);
  assign w_resp     = w_done && ex_wb_pipe_i.lsu_en;
  assign w_first    = ex_wb_pipe_i.lsu_en && ex_wb_pipe_i.lsu_misaligned_first;
  assign w_bus_err  = w_resp && lsu_err_i;
  // Second part of an access whose first part already faulted.
  assign w_suppress = ex_wb_pipe_i.lsu_en && r_err_q;
  assign w_misal    = (r_state == S_MISAL);

  cv32e40x_wb_load_align u_load_align (
    .i_rdata   (lsu_rdata_i),
    .i_rdata_q (r_rdata_q),
    .i_off     (w_misal ? r_off_q : ex_wb_pipe_i.lsu_addr_lsb),
    .i_size    (ex_wb_pipe_i.lsu_size),
    .i_sext    (ex_wb_pipe_i.lsu_sext),
    .i_misal   (w_misal),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_fsm_i.kill_wb)
      w_state_nxt = S_IDLE;
    else if (w_resp)
      w_state_nxt = (w_first && !lsu_err_i) ? S_MISAL : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_q <= '0;
      r_off_q   <= '0;
      r_err_q   <= 1'b0;
    end else if (ctrl_fsm_i.kill_wb) begin
      r_rdata_q <= '0;
      r_off_q   <= '0;
      r_err_q   <= 1'b0;
    end else if (w_resp) begin
      if (w_first && !lsu_err_i) begin
        r_rdata_q <= lsu_rdata_i;
        r_off_q   <= ex_wb_pipe_i.lsu_addr_lsb;
      end
      r_err_q <= w_first && lsu_err_i;
    end
  end

  assign lsu_ready_o  = ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.lsu_en && !ctrl_fsm_i.halt_wb;
  assign rf_we_o      = w_done && ex_wb_pipe_i.rf_we && !ex_wb_pipe_i.illegal_insn &&
                        !w_bus_err && !w_suppress;
  assign rf_waddr_o   = ex_wb_pipe_i.rf_waddr;
  assign rf_wdata_o   = ex_wb_pipe_i.lsu_en ? w_load_data : ex_wb_pipe_i.rf_wdata;
  assign csr_we_o     = w_done && ex_wb_pipe_i.csr_en && !ex_wb_pipe_i.illegal_insn;
  assign csr_addr_o   = ex_wb_pipe_i.csr_addr;
  assign csr_wdata_o  = ex_wb_pipe_i.csr_wdata;
  assign wb_valid_o   = w_done && !w_first;
  assign wb_bus_err_o = w_bus_err && !r_err_q;
  assign wb_ready_o   = ctrl_fsm_i.kill_wb || !ex_wb_pipe_i.instr_valid || w_done;

`ifndef SYNTHESIS
  a_stray_resp: assert property (@(posedge clk) disable iff (rst)
    lsu_valid_i |-> (ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.lsu_en));
  a_halt_resp: assert property (@(posedge clk) disable iff (rst)
    lsu_valid_i |-> !ctrl_fsm_i.halt_wb);
`endif

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Self-checking bench for cv32e40x_wb_stage: directed scenarios followed by
// randomized instruction streams checked against a byte-level load model.
module tb_cv32e40x_wb_stage;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_wb_pipe_t pipe;
  ctrl_fsm_t   ctrl;
  logic        lsu_valid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        lsu_ready, rf_we, csr_we, wb_valid, wb_bus_err, wb_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata;
  logic [11:0] csr_addr;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state: bytes delivered by a pending first part.
  logic [7:0]  m_bytes [4];
  int          m_nfirst;
  bit          m_err;
  logic [31:0] last_wdata;

  cv32e40x_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wb_pipe_i (pipe),
    .ctrl_fsm_i   (ctrl),
    .lsu_valid_i  (lsu_valid),
    .lsu_rdata_i  (lsu_rdata),
    .lsu_err_i    (lsu_err),
    .lsu_ready_o  (lsu_ready),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .csr_we_o     (csr_we),
    .csr_addr_o   (csr_addr),
    .csr_wdata_o  (csr_wdata),
    .wb_valid_o   (wb_valid),
    .wb_bus_err_o (wb_bus_err),
    .wb_ready_o   (wb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in;
    pipe      = '0;
    ctrl      = '0;
    lsu_valid = 1'b0;
    lsu_err   = 1'b0;
    lsu_rdata = '0;
  endtask

  task automatic model_reset;
    m_err    = 1'b0;
    m_nfirst = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit ill);
    clear_in;
    pipe.instr_valid  = 1'b1;
    pipe.rf_we        = 1'b1;
    pipe.rf_waddr     = rd;
    pipe.rf_wdata     = d;
    pipe.illegal_insn = ill;
    #5;
    chk("alu_we", rf_we, !ill);
    if (!ill) begin
      chk("alu_waddr", rf_waddr, rd);
      chk("alu_wdata", rf_wdata, d);
    end
    chk("alu_valid", wb_valid, 1);
    chk("alu_ready", wb_ready, 1);
    chk("alu_csr_we", csr_we, 0);
    last_wdata = rf_wdata;
    tick;
    clear_in;
  endtask

  task automatic csr(input logic [11:0] a, input logic [31:0] d, input bit ill);
    clear_in;
    pipe.instr_valid  = 1'b1;
    pipe.csr_en       = 1'b1;
    pipe.csr_addr     = a;
    pipe.csr_wdata    = d;
    pipe.illegal_insn = ill;
    #5;
    chk("csr_we", csr_we, !ill);
    chk("csr_addr", csr_addr, a);
    chk("csr_wdata", csr_wdata, d);
    chk("csr_rf_we", rf_we, 0);
    chk("csr_valid", wb_valid, 1);
    tick;
    clear_in;
  endtask

  // kind: 0 aligned, 1 first part of misaligned, 2 second part.
  task automatic load(input int kind, input int size, input int off, input bit sext,
                      input logic [31:0] rdata, input bit err, input int waits,
                      input logic [4:0] rd);
    int          nb;
    logic [31:0] v;
    logic [7:0]  b;
    bit          we_exp, bus_exp;
    clear_in;
    pipe.instr_valid          = 1'b1;
    pipe.lsu_en               = 1'b1;
    pipe.rf_we                = (kind != 1);
    pipe.rf_waddr             = rd;
    pipe.rf_wdata             = $urandom;
    pipe.lsu_size             = lsu_size_e'(size[1:0]);
    pipe.lsu_sext             = sext;
    pipe.lsu_addr_lsb         = off[1:0];
    pipe.lsu_misaligned_first = (kind == 1);
    for (int w = 0; w < waits; w++) begin
      #5;
      chk("wait_ready", wb_ready, 0);
      chk("wait_we", rf_we, 0);
      chk("wait_valid", wb_valid, 0);
      chk("wait_lsu_ready", lsu_ready, 1);
      tick;
    end
    lsu_valid = 1'b1;
    lsu_rdata = rdata;
    lsu_err   = err;
    nb = 1 << size;
    v  = '0;
    for (int i = 0; i < nb; i++) begin
      if (kind == 2) b = (i < m_nfirst) ? m_bytes[i] : rdata[8*(i-m_nfirst) +: 8];
      else           b = rdata[8*(off+i) +: 8];
      v = v | (32'(b) << (8*i));
    end
    if (sext && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    we_exp  = !err && !(kind == 2 && m_err) && (kind != 1);
    bus_exp = err && !(kind == 2 && m_err);
    #5;
    chk("ld_we", rf_we, we_exp);
    if (we_exp) begin
      chk("ld_waddr", rf_waddr, rd);
      chk("ld_wdata", rf_wdata, v);
    end
    chk("ld_valid", wb_valid, kind != 1);
    chk("ld_bus_err", wb_bus_err, bus_exp);
    chk("ld_ready", wb_ready, 1);
    chk("ld_lsu_ready", lsu_ready, 1);
    last_wdata = rf_wdata;
    tick;
    clear_in;
    if (kind == 1) begin
      m_err = err;
      if (!err) begin
        for (int j = off; j < 4; j++) m_bytes[j-off] = rdata[8*j +: 8];
        m_nfirst = 4 - off;
      end
    end else begin
      m_err = 1'b0;
    end
  endtask

  initial begin
    clear_in;
    model_reset;
    last_wdata = '0;
    rst = 1'b1;
    tick;
    #5;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_bus_err", wb_bus_err, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_wb_ready", wb_ready, 1);
    tick;
    rst = 1'b0;
    tick;

    alu(5'd5, 32'h0000_0007, 1'b0);

    load(0, 0, 3, 1'b1, 32'h80AA_BBCC, 1'b0, 3, 5'd6);
    chk("lb_sext_value", last_wdata, 32'hFFFF_FF80);

    load(1, 2, 2, 1'b0, 32'h1122_3344, 1'b0, 0, 5'd7);
    load(2, 2, 0, 1'b0, 32'h5566_7788, 1'b0, 1, 5'd7);
    chk("misal_lw_value", last_wdata, 32'h7788_1122);

    // Errored first part: single pulse, second part consumed without write.
    load(1, 1, 3, 1'b0, 32'h0102_0304, 1'b1, 0, 5'd9);
    load(2, 1, 0, 1'b0, 32'h0000_FFFF, 1'b0, 0, 5'd9);
    load(0, 2, 0, 1'b0, 32'h1234_5678, 1'b0, 0, 5'd3);
    chk("after_err_value", last_wdata, 32'h1234_5678);

    // Kill while waiting for the second part, with a response in the same cycle.
    load(1, 2, 0 + 1, 1'b0, 32'hAABB_CCDD, 1'b0, 0, 5'd4);
    pipe.instr_valid  = 1'b1;
    pipe.lsu_en       = 1'b1;
    pipe.rf_we        = 1'b1;
    pipe.rf_waddr     = 5'd4;
    pipe.lsu_size     = LSU_SIZE_W;
    ctrl.kill_wb      = 1'b1;
    lsu_valid         = 1'b1;
    lsu_rdata         = 32'h9999_9999;
    #5;
    chk("kill_we", rf_we, 0);
    chk("kill_valid", wb_valid, 0);
    chk("kill_ready", wb_ready, 1);
    chk("kill_bus_err", wb_bus_err, 0);
    tick;
    clear_in;
    model_reset;
    load(0, 2, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 5'd8);
    chk("post_kill_value", last_wdata, 32'hDEAD_BEEF);

    // Halted CSR write is held, then completes on release.
    pipe.instr_valid = 1'b1;
    pipe.csr_en      = 1'b1;
    pipe.csr_addr    = 12'h300;
    pipe.csr_wdata   = 32'h0000_CAFE;
    ctrl.halt_wb     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #5;
      chk("halt_csr_we", csr_we, 0);
      chk("halt_lsu_ready", lsu_ready, 0);
      chk("halt_valid", wb_valid, 0);
      chk("halt_ready", wb_ready, 0);
      tick;
    end
    ctrl.halt_wb = 1'b0;
    #5;
    chk("rel_csr_we", csr_we, 1);
    chk("rel_csr_addr", csr_addr, 12'h300);
    chk("rel_csr_wdata", csr_wdata, 32'h0000_CAFE);
    tick;
    clear_in;

    // Halt on a pending load blocks the response handshake.
    pipe.instr_valid = 1'b1;
    pipe.lsu_en      = 1'b1;
    ctrl.halt_wb     = 1'b1;
    #5;
    chk("halt_ld_lsu_ready", lsu_ready, 0);
    chk("halt_ld_ready", wb_ready, 0);
    tick;
    load(0, 1, 2, 1'b1, 32'h8001_0000, 1'b0, 1, 5'd10);
    chk("lh_sext_value", last_wdata, 32'hFFFF_8001);

    // Reset in the middle of a misaligned pair discards the first part.
    load(1, 2, 3, 1'b0, 32'h5555_5555, 1'b0, 0, 5'd11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset;
    tick;
    load(0, 2, 0, 1'b0, 32'hA5A5_0F0F, 1'b0, 0, 5'd11);
    chk("post_rst_value", last_wdata, 32'hA5A5_0F0F);

    for (int it = 0; it < 80; it++) begin
      int k, sz, off;
      bit sx;
      k  = $urandom_range(0, 4);
      sx = 1'($urandom_range(0, 1));
      case (k)
        0: alu(5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 7) == 0);
        1: csr(12'($urandom), $urandom, $urandom_range(0, 7) == 0);
        2: begin
          sz  = $urandom_range(0, 2);
          off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? $urandom_range(0, 2) : 0;
          load(0, sz, off, sx, $urandom, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3), 5'($urandom_range(1, 31)));
        end
        3: begin
          if ($urandom_range(0, 1) == 1) begin
            sz  = 2;
            off = $urandom_range(1, 3);
          end else begin
            sz  = 1;
            off = 3;
          end
          load(1, sz, off, sx, $urandom, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2), 5'd12);
          load(2, sz, 0, sx, $urandom, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2), 5'd12);
        end
        default: begin
          clear_in;
          #5;
          chk("idle_ready", wb_ready, 1);
          chk("idle_we", rf_we, 0);
          chk("idle_valid", wb_valid, 0);
          tick;
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
